// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared geometry and FSM state encodings for the FIFO controller
package fifo_ctrl_pkg;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int CW = 4;
  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    WR_ERROR = 3'd3,
    READ     = 3'd4,
    RD_ERROR = 3'd5
  } state_e;
endpackage

// File: rtl/fifo_ctrl_ns.sv
// fifo_ctrl_ns: next-state, pointer/count update and strobe decode for the FIFO controller
module fifo_ctrl_ns
  import fifo_ctrl_pkg::*;
(
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [CW-1:0] count,
  input  logic [AW-1:0] head,
  input  logic [AW-1:0] tail,
  output state_e        next_state,
  output logic [AW-1:0] next_head,
  output logic [AW-1:0] next_tail,
  output logic [CW-1:0] next_count,
  output logic          wr_strobe,
  output logic          rd_strobe
);
  logic w, r, full, empty;
  always_comb begin
    w = wr_en & ~rd_en;
    r = rd_en & ~wr_en;
    full = count == CW'(DEPTH);
    empty = count == '0;
    wr_strobe = w & ~full;
    rd_strobe = r & ~empty;
    // pointers roll over naturally at AW bits; only count separates full from empty
    next_head = rd_strobe ? head + 1'b1 : head;
    next_tail = wr_strobe ? tail + 1'b1 : tail;
    next_count = wr_strobe ? count + 1'b1 : rd_strobe ? count - 1'b1 : count;
    next_state = w ? (full ? WR_ERROR : WRITE) : r ? (empty ? RD_ERROR : READ) : NO_OP;
  end
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/count registers, operation FSM and handshake decode for an 8x32 FIFO
module fifo_ctrl
  import fifo_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic          rd_strobe,
  output logic [AW-1:0] rd_addr,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] data_count,
  output logic [2:0]    state,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err
);
  state_e state_q, state_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic ns_wr_strobe, ns_rd_strobe;
  fifo_ctrl_ns u_ns (
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .count      (count_q),
    .head       (head_q),
    .tail       (tail_q),
    .next_state (state_d),
    .next_head  (head_d),
    .next_tail  (tail_d),
    .next_count (count_d),
    .wr_strobe  (ns_wr_strobe),
    .rd_strobe  (ns_rd_strobe)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  // strobes are gated by reset so nothing reaches the register file mid-reset
  always_comb begin
    wr_strobe = ns_wr_strobe & ~reset;
    rd_strobe = ns_rd_strobe & ~reset;
    wr_addr = tail_q;
    rd_addr = head_q;
    full = count_q == CW'(DEPTH);
    empty = count_q == '0;
    data_count = count_q;
    state = state_q;
    wr_ack = state_q == WRITE;
    wr_err = state_q == WR_ERROR;
    rd_ack = state_q == READ;
    rd_err = state_q == RD_ERROR;
  end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed and random checks of fifo_ctrl against a queue-based FIFO model
module tb_fifo_ctrl;
  logic clk = 0, reset = 1, wr_en = 0, rd_en = 0;
  logic wr_strobe, rd_strobe, full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [2:0] wr_addr, rd_addr, state;
  logic [3:0] data_count;
  int compared = 0, mismatched = 0;
  int q[$];
  int wptr = 0, exp_st = 0;
  bit last_w = 0, last_we = 0, last_r = 0, last_re = 0;

  fifo_ctrl dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .rd_strobe(rd_strobe), .rd_addr(rd_addr),
    .full(full), .empty(empty), .data_count(data_count), .state(state),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".state"}, int'(state), exp_st);
    chk({tag, ".count"}, int'(data_count), q.size());
    chk({tag, ".full"}, int'(full), int'(q.size() == 8));
    chk({tag, ".empty"}, int'(empty), int'(q.size() == 0));
    chk({tag, ".wr_ack"}, int'(wr_ack), int'(last_w));
    chk({tag, ".wr_err"}, int'(wr_err), int'(last_we));
    chk({tag, ".rd_ack"}, int'(rd_ack), int'(last_r));
    chk({tag, ".rd_err"}, int'(rd_err), int'(last_re));
  endtask

  task automatic model_reset();
    q.delete();
    wptr = 0;
    exp_st = 0;
    {last_w, last_we, last_r, last_re} = '0;
  endtask

  // called at a negedge: drive, check combinational outputs, clock, check registered outputs
  task automatic step(input bit we, input bit re, input string tag);
    bit w, r, ws, rs;
    wr_en = we;
    rd_en = re;
    w = we && !re;
    r = re && !we;
    ws = w && q.size() < 8;
    rs = r && q.size() > 0;
    #1;
    chk({tag, ".wr_strobe"}, int'(wr_strobe), int'(ws));
    chk({tag, ".rd_strobe"}, int'(rd_strobe), int'(rs));
    chk({tag, ".wr_addr"}, int'(wr_addr), wptr);
    chk({tag, ".rd_addr"}, int'(rd_addr), q.size() > 0 ? q[0] : wptr);
    {last_w, last_we, last_r, last_re} = {ws, w && !ws, rs, r && !rs};
    if (ws) begin q.push_back(wptr); wptr = (wptr + 1) % 8; exp_st = 2; end
    else if (w) exp_st = 3;
    else if (rs) begin void'(q.pop_front()); exp_st = 4; end
    else if (r) exp_st = 5;
    else exp_st = 1;
    @(posedge clk);
    #1;
    chk_regs(tag);
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk_regs("reset");
    chk("reset.wr_strobe", int'(wr_strobe), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) step(0, 0, "idle");
    for (int i = 0; i < 9; i++) step(1, 0, "fill");
    for (int i = 0; i < 9; i++) step(0, 1, "drain");
    for (int i = 0; i < 5; i++) step(1, 0, "wrap_w5");
    for (int i = 0; i < 5; i++) step(0, 1, "wrap_r5");
    for (int i = 0; i < 6; i++) step(1, 0, "wrap_w6");
    for (int i = 0; i < 3; i++) step(0, 1, "wrap_r");
    step(1, 1, "both");
    step(1, 1, "both2");
    for (int i = 0; i < 3; i++) step(0, 1, "wrap_r_rest");
    for (int i = 0; i < 4; i++) step(1, 0, "pre_reset");
    wr_en = 1;
    rd_en = 0;
    #2 reset = 1;
    #1;
    model_reset();
    chk_regs("async_reset");
    chk("async_reset.wr_strobe", int'(wr_strobe), 0);
    chk("async_reset.wr_addr", int'(wr_addr), 0);
    chk("async_reset.rd_addr", int'(rd_addr), 0);
    @(posedge clk);
    #1;
    chk_regs("held_reset");
    chk("held_reset.wr_strobe", int'(wr_strobe), 0);
    @(negedge clk);
    reset = 0;
    step(1, 0, "post_reset_w");
    for (int i = 0; i < 400; i++) begin
      int v = $urandom_range(0, 3);
      step(v[0], v[1], "rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control unit for the 8-entry x 32-bit FIFO.
- Owns head/tail pointers, occupancy count and the operation state machine.
- Drives the write address/strobe into the register file and the 3-bit read address into the FIFO read mux.
- Returns per-request ack/error handshakes and full/empty/count status to the requester.

Parameters:
DEPTH, 8, number of FIFO entries (power of two)
AW, 3, pointer/address width, log2(DEPTH)
CW, 4, count width, AW+1 (holds 0..DEPTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
wr_en  input  1  write request, sampled each rising edge
rd_en  input  1  read request, sampled each rising edge
wr_strobe  output  1  register-file write enable (combinational)
wr_addr  output  AW  register-file write address = tail
rd_strobe  output  1  consumer capture strobe for read-mux data (combinational)
rd_addr  output  AW  read-mux select = head
full  output  1  count == DEPTH
empty  output  1  count == 0
data_count  output  CW  current occupancy
state  output  3  current FSM state (debug/observe)
wr_ack  output  1  registered: previous cycle's write accepted
wr_err  output  1  registered: previous cycle's write rejected (full)
rd_ack  output  1  registered: previous cycle's read accepted
rd_err  output  1  registered: previous cycle's read rejected (empty)

Behaviour:
- Reset, asynchronous, any time including mid-operation:
  - state=INIT; head=0, tail=0, count=0.
  - wr_ack, wr_err, rd_ack, rd_err = 0; empty=1, full=0.
  - No strobe may fire while reset is high.
- Request decode, on registered status:
  - W = wr_en & ~rd_en.
  - R = rd_en & ~wr_en.
  - Both asserted or neither asserted -> no operation.
- wr_strobe = W & ~full; rd_strobe = R & ~empty; both gated by ~reset.
- Write accepted: the register file writes at the same edge at tail. At that edge: tail<=tail+1 (mod DEPTH), count<=count+1, state<=WRITE.
- Read accepted: read-mux data at rd_addr=head is valid combinationally in the same cycle and the consumer captures it on that edge. At that edge: head<=head+1 (mod DEPTH), count<=count-1, state<=READ.
- FSM states, 3-bit encoding: INIT=0, NO_OP=1, WRITE=2, WR_ERROR=3, READ=4, RD_ERROR=5.
- Next-state rules, from any state including INIT, evaluated on the current edge:
  - W & ~full -> WRITE.
  - W & full -> WR_ERROR; pointers and count unchanged.
  - R & ~empty -> READ.
  - R & empty -> RD_ERROR; pointers and count unchanged.
  - otherwise -> NO_OP.
- Handshake outputs are decoded from the registered state and are one-hot-or-zero:
  - wr_ack = (state==WRITE)
  - wr_err = (state==WR_ERROR)
  - rd_ack = (state==READ)
  - rd_err = (state==RD_ERROR)
- Latency: request sampled at edge N; ack/err valid during cycle N..N+1; full/empty/data_count updated after edge N.
- Pointer wrap-around is natural AW-bit rollover; full vs empty is disambiguated only by count, never by pointer compare.
- Count never exceeds DEPTH and never underflows.
- Back-to-back requests are allowed every cycle; no bubble is required between a write and a read.

Decomposition:
- Shared package fifo_ctrl_pkg holds:
  - state encodings INIT..RD_ERROR
  - DEPTH/AW/CW defaults
- Sub-module fifo_ctrl_ns (combinational): takes state-independent inputs wr_en, rd_en, count. Returns:
  - next_state
  - next_head, next_tail, next_count
  - wr_strobe, rd_strobe
- Top fifo_ctrl holds the registers and output decode.

Test Plan:
- Reset then idle 3 cycles -> state=NO_OP after first edge; empty=1, full=0, data_count=0; all acks/errs 0.
- 8 consecutive writes -> wr_addr 0..7 with wr_strobe each cycle; wr_ack=1 for 8 cycles; data_count=8, full=1. 9th write -> wr_strobe=0, wr_err=1, data_count stays 8.
- From full, 8 reads -> rd_addr 0..7 with rd_strobe; rd_ack=1 each; data_count=0, empty=1. 9th read -> rd_err=1, rd_addr stays 0.
- Wrap: write 5, read 5, write 6 -> wr_addr sequence 5,6,7,0,1,2; data_count=6; following reads give rd_addr 5,6,7,0,1,2.
- wr_en=rd_en=1 with data_count=3 -> state=NO_OP, no strobes, no acks, count stays 3.
- Write 4 entries, assert reset mid-write -> immediately head=tail=0, count=0, state=INIT, wr_ack=0. First write after reset lands at wr_addr=0.
